// File: rtl/l2_prefetch_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : l2_prefetch_fill                                              |
// | Brief    : L2 prefetch buffer burst filler and flush sweeper. Optional   |
// |            sequential next-burst fill enabled by L2_PREFETCH_NEXT_EN.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module l2_prefetch_fill #(
  parameter int BURST_LEN = 8,
  parameter int IDX_N     = 128
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic        MissReq,
  input  logic [25:0] MissA,
  input  logic        Flush,
  output logic        Busy,
  output logic        MemReq,
  output logic [25:0] MemA,
  input  logic        MemAck,
  input  logic        MemDV,
  input  logic [31:0] MemD,
  output logic [25:0] WRA,
  output logic [31:0] WRD,
  output logic        WR,
  output logic [3:0]  WRM,
  output logic        CLR
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IW = (IDX_N > 1) ? $clog2(IDX_N) : 1;
  localparam logic [25:0]   ALIGN_MASK = ~(26'(BURST_LEN - 1));
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(IDX_N - 1);
`ifdef L2_PREFETCH_NEXT_EN
  localparam logic [25:0]   BURST_STEP = 26'(BURST_LEN);
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_FLUSH} state_t;

  state_t        state;
  logic [25:0]   base;
  logic [BW-1:0] beat;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          flush_pend;
`ifdef L2_PREFETCH_NEXT_EN
  logic          seq_pend;
  logic          seq_fill;
`endif

  assign Busy     = (state != S_IDLE);
  assign idx_next = idx + 1'b1;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state      <= S_IDLE;
      base       <= '0;
      beat       <= '0;
      idx        <= '0;
      flush_pend <= 1'b0;
      MemReq     <= 1'b0;
      MemA       <= '0;
      WRA        <= '0;
      WRD        <= '0;
      WR         <= 1'b0;
      WRM        <= 4'b0000;
      CLR        <= 1'b0;
`ifdef L2_PREFETCH_NEXT_EN
      seq_pend   <= 1'b0;
      seq_fill   <= 1'b0;
`endif
    end else begin
      // Write strobe and its qualifiers are single-cycle unless re-armed below.
      WR  <= 1'b0;
      WRM <= 4'b0000;
      CLR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Flush || flush_pend) begin
            state      <= S_FLUSH;
            flush_pend <= 1'b0;
            idx        <= '0;
            WR         <= 1'b1;
            CLR        <= 1'b1;
            WRM        <= 4'b1111;
            WRD        <= '0;
            WRA        <= '0;
`ifdef L2_PREFETCH_NEXT_EN
            seq_pend   <= 1'b0;
`endif
          end else if (MissReq) begin
            state  <= S_REQ;
            base   <= MissA & ALIGN_MASK;
            MemA   <= MissA & ALIGN_MASK;
            MemReq <= 1'b1;
`ifdef L2_PREFETCH_NEXT_EN
            seq_pend <= 1'b0;
            seq_fill <= 1'b0;
          end else if (seq_pend) begin
            state    <= S_REQ;
            base     <= base + BURST_STEP;
            MemA     <= base + BURST_STEP;
            MemReq   <= 1'b1;
            seq_pend <= 1'b0;
            seq_fill <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (Flush) flush_pend <= 1'b1;
          if (MemAck) begin
            state  <= S_DATA;
            MemReq <= 1'b0;
            beat   <= '0;
          end
        end
        S_DATA: begin
          if (Flush) flush_pend <= 1'b1;
          if (MemDV) begin
            WR   <= 1'b1;
            WRM  <= 4'b1111;
            WRD  <= MemD;
            WRA  <= base + {{(26-BW){1'b0}}, beat};
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= S_IDLE;
`ifdef L2_PREFETCH_NEXT_EN
              // Only a demand burst chains a sequential fill, and a flush cancels it.
              seq_pend <= !seq_fill && !(flush_pend || Flush);
`endif
            end
          end
        end
        S_FLUSH: begin
          WR  <= 1'b1;
          CLR <= 1'b1;
          WRM <= 4'b1111;
          WRD <= '0;
          if (Flush) begin
            idx <= '0;
            WRA <= '0;
          end else if (idx == LAST_IDX) begin
            state <= S_IDLE;
            WR    <= 1'b0;
            CLR   <= 1'b0;
            WRM   <= 4'b0000;
          end else begin
            idx <= idx_next;
            WRA <= {{(26-IW){1'b0}}, idx_next};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_prefetch_fill.sv
`default_nettype none
// Bench for l2_prefetch_fill: table-driven fills, directed corner sequences and
// randomized traffic checked against an expected-write scoreboard.
module tb_l2_prefetch_fill;
  localparam int BL  = 8;
  localparam int IDX = 128;

  logic        CLK = 1'b0;
  logic        nRES = 1'b0;
  logic        MissReq = 1'b0;
  logic [25:0] MissA = '0;
  logic        Flush = 1'b0;
  logic        MemAck = 1'b0;
  logic        MemDV = 1'b0;
  logic [31:0] MemD = '0;
  logic        Busy, MemReq, WR, CLR;
  logic [25:0] MemA, WRA;
  logic [31:0] WRD;
  logic [3:0]  WRM;

  l2_prefetch_fill #(.BURST_LEN(BL), .IDX_N(IDX)) dut (
    .CLK(CLK), .nRES(nRES), .MissReq(MissReq), .MissA(MissA), .Flush(Flush),
    .Busy(Busy), .MemReq(MemReq), .MemA(MemA), .MemAck(MemAck), .MemDV(MemDV),
    .MemD(MemD), .WRA(WRA), .WRD(WRD), .WR(WR), .WRM(WRM), .CLR(CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [25:0] a; logic [31:0] d; logic clr; } wr_t;
  typedef struct { logic [25:0] miss; logic [25:0] base; } vec_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic flush_req = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every buffer write must match the next expected write, in order.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (WR) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wr: got WRA=0x%0h WRD=0x%0h CLR=%0b, expected no write", WRA, WRD, CLR);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {38'd0, WRA}, {38'd0, e.a});
          chk("wr_data", {32'd0, WRD}, {32'd0, e.d});
          chk("wr_clr", {63'd0, CLR}, {63'd0, e.clr});
          chk("wr_mask", {60'd0, WRM}, 64'hF);
        end
      end else begin
        chk("idle_mask_clr", {59'd0, WRM, CLR}, 64'd0);
      end
    end
  end

  task automatic push_flush();
    for (int i = 0; i < IDX; i++) exp_q.push_back('{a: 26'(i), d: 32'd0, clr: 1'b1});
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (Busy && t < IDX * 4) begin
      @(negedge CLK);
      t++;
    end
    chk("wait_idle", {63'd0, Busy}, 64'd0);
  endtask

  // Serves one fill request; fb = beat index carrying a Flush pulse, BL = pulse in REQ, <0 none.
  task automatic serve_burst(input logic [25:0] eb, input int ack_dly, input int fb, input int nbeats);
    int t;
    int gap;
    logic [31:0] dat;
    t = 0;
    while (!MemReq && t < 400) begin
      @(negedge CLK);
      t++;
    end
    MissReq = 1'b0;
    chk("memreq_rise", {63'd0, MemReq}, 64'd1);
    chk("mema", {38'd0, MemA}, {38'd0, eb});
    chk("queue_drained_at_req", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge CLK);
      chk("memreq_hold", {63'd0, MemReq}, 64'd1);
      chk("mema_hold", {38'd0, MemA}, {38'd0, eb});
      chk("no_wr_in_req", {63'd0, WR}, 64'd0);
    end
    MemAck = 1'b1;
    if (fb == BL) begin
      Flush = 1'b1;
      flush_req = 1'b1;
    end
    @(negedge CLK);
    MemAck = 1'b0;
    Flush = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge CLK);
      dat = $urandom;
      MemDV = 1'b1;
      MemD = dat;
      exp_q.push_back('{a: eb + 26'(b), d: dat, clr: 1'b0});
      if (b == fb) begin
        Flush = 1'b1;
        flush_req = 1'b1;
      end
      @(negedge CLK);
      MemDV = 1'b0;
      Flush = 1'b0;
    end
  endtask

  task automatic do_miss(input logic [25:0] a, input logic [25:0] eb, input int ack_dly,
                         input int fb, input bit with_flush);
    flush_req = 1'b0;
    MissA = a;
    MissReq = 1'b1;
    if (with_flush) begin
      Flush = 1'b1;
      push_flush();
      @(negedge CLK);
      Flush = 1'b0;
    end
    serve_burst(eb, ack_dly, fb, BL);
    chk("busy_low_after_burst", {63'd0, Busy}, 64'd0);
    if (flush_req) begin
      push_flush();
      @(negedge CLK);
      chk("flush_follows_burst_clr", {63'd0, CLR}, 64'd1);
      chk("flush_follows_burst_wra", {38'd0, WRA}, 64'd0);
      flush_req = 1'b0;
      wait_idle();
    end
`ifdef L2_PREFETCH_NEXT_EN
    else begin
      serve_burst(eb + 26'(BL), 0, -1, BL);
      chk("busy_low_after_seq", {63'd0, Busy}, 64'd0);
    end
`endif
    repeat (3) @(negedge CLK);
    chk("no_further_req", {63'd0, MemReq}, 64'd0);
    chk("idle_after_fill", {63'd0, Busy}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_flush();
    Flush = 1'b1;
    push_flush();
    @(negedge CLK);
    Flush = 1'b0;
    chk("flush_busy", {63'd0, Busy}, 64'd1);
    wait_idle();
    @(negedge CLK);
    chk("flush_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{miss: 26'h0000013, base: 26'h0000010};
    vt[1] = '{miss: 26'h3FFFFFC, base: 26'h3FFFFF8};
    vt[2] = '{miss: 26'h0000007, base: 26'h0000000};
    vt[3] = '{miss: 26'h1234567, base: 26'h1234560};
    vt[4] = '{miss: 26'h0000008, base: 26'h0000008};

    #1;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_memreq", {63'd0, MemReq}, 64'd0);
    chk("rst_wr", {63'd0, WR}, 64'd0);
    chk("rst_wrm_clr", {59'd0, WRM, CLR}, 64'd0);
    chk("rst_mema", {38'd0, MemA}, 64'd0);
    chk("rst_wra", {38'd0, WRA}, 64'd0);
    chk("rst_wrd", {32'd0, WRD}, 64'd0);
    repeat (2) @(negedge CLK);
    nRES = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) do_miss(vt[i].miss, vt[i].base, i, -1, 1'b0);

    // Ack withheld for 50 cycles.
    do_miss(26'h0ABCDE5, 26'h0ABCDE0, 50, -1, 1'b0);
    // Flush during beat 3, then a flush pulse while still in REQ.
    do_miss(26'h0000100, 26'h0000100, 1, 3, 1'b0);
    do_miss(26'h0000333, 26'h0000330, 2, BL, 1'b0);
    // Miss and Flush in the same idle cycle: flush sweep first, then the fill.
    do_miss(26'h0000205, 26'h0000200, 0, -1, 1'b1);

    // Flush restarted mid-sweep after index 9.
    Flush = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back('{a: 26'(k), d: 32'd0, clr: 1'b1});
    @(negedge CLK);
    Flush = 1'b0;
    repeat (9) @(negedge CLK);
    Flush = 1'b1;
    push_flush();
    @(negedge CLK);
    Flush = 1'b0;
    wait_idle();
    @(negedge CLK);
    chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset after beat 4, then stray beats must be dropped.
    MissA = 26'h0000040;
    MissReq = 1'b1;
    flush_req = 1'b0;
    serve_burst(26'h0000040, 1, -1, 5);
    chk("wr_high_before_reset", {63'd0, WR}, 64'd1);
    #2 nRES = 1'b0;
    #1;
    chk("async_rst_wr", {63'd0, WR}, 64'd0);
    chk("async_rst_memreq", {63'd0, MemReq}, 64'd0);
    chk("async_rst_busy", {63'd0, Busy}, 64'd0);
    chk("async_rst_wrm_clr", {59'd0, WRM, CLR}, 64'd0);
    chk("async_rst_wra", {38'd0, WRA}, 64'd0);
    repeat (2) @(negedge CLK);
    nRES = 1'b1;
    for (int k = 0; k < 3; k++) begin
      MemDV = 1'b1;
      MemD = $urandom;
      @(negedge CLK);
      MemDV = 1'b0;
      chk("no_wr_after_reset", {63'd0, WR}, 64'd0);
    end
    @(negedge CLK);
    chk("no_wr_after_reset_tail", {63'd0, WR}, 64'd0);
    chk("idle_after_reset", {63'd0, Busy}, 64'd0);

    // Randomized traffic against the scoreboard.
    for (int r = 0; r < 25; r++) begin
      int op;
      int fb;
      logic [25:0] a;
      op = int'($urandom_range(0, 9));
      a = 26'($urandom);
      fb = -1;
      if ($urandom_range(0, 3) == 0) fb = int'($urandom_range(0, BL));
      if (op == 0) do_flush();
      else do_miss(a, a - (a % 26'(BL)), int'($urandom_range(0, 4)), fb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
